pb_gpio_ctrl: RTL and testbench
===============================

# pb_gpio_ctrl

PicoBlaze port-mapped register bank and interrupt controller on the firmware side of `pb_gpio`. It decodes KCPSM `port_id`/`write_strobe` cycles into the `gpio_data_i`, `gpio_oe` and `gpio_enable` control bytes. It returns `gpio_data_o` and the interrupt status on `in_port`. It also turns pin edges into a sticky, maskable interrupt, asserted to the processor on `interrupt_o` and released with the KCPSM `interrupt_ack` handshake.

## Interface
- `BASE_ADDR`, default 8'h00: port address of register 0; must be a multiple of 8. The block occupies `BASE_ADDR`..`BASE_ADDR`+7.
- `clk_i` input 1: system clock; all logic on the rising edge.
- `rst_n_i` input 1: reset, asynchronous and active-low.
- `port_id_i` input 8: KCPSM port address.
- `write_strobe_i` input 1: KCPSM output strobe, one cycle.
- `out_port_i` input 8: KCPSM write data.
- `in_port_o` output 8: registered read data to KCPSM.
- `interrupt_o` output 1: interrupt request to KCPSM.
- `interrupt_ack_i` input 1: KCPSM interrupt acknowledge, one cycle.
- `gpio_data_o` output 8: DATA_OUT register; connects to `pb_gpio.gpio_data_i`.
- `gpio_oe_o` output 8: OE register; connects to `pb_gpio.gpio_oe`.
- `gpio_enable_o` output 8: ENABLE register; connects to `pb_gpio.gpio_enable`.
- `gpio_in_i` input 8: sampled pin values from `pb_gpio.gpio_data_o`.

## Operation
- Address decode:
  - Hit when `port_id_i[7:3]` == `BASE_ADDR[7:3]`; the offset is `port_id_i[2:0]`.
  - A write occurs on a hit qualified by `write_strobe_i`.
  - Any other port address neither writes nor affects reads.
- Register map (offset: name, access):
  - 0: DATA_OUT, RW.
  - 1: OE, RW.
  - 2: ENABLE, RW.
  - 3: DATA_IN, RO; returns `gpio_in_i`; writes are ignored.
  - 4: IRQ_MASK, RW.
  - 5: RISE_EN, RW.
  - 6: FALL_EN, RW.
  - 7: IRQ_STATUS, read returns status, write-1-to-clear.
- Read path: `in_port_o` <= mux(offset) on every clock whenever there is a hit. On a miss, `in_port_o` <= 8'h00. Reads have no side effects.
- Edge detection:
  - `prev` <= `gpio_in_i` every cycle.
  - `qual[i]` = `gpio_enable_o[i]` & ~`gpio_oe_o[i]`.
  - `rise[i]` = `qual[i]` & `RISE_EN[i]` & `gpio_in_i[i]` & ~`prev[i]`.
  - `fall[i]` = `qual[i]` & `FALL_EN[i]` & ~`gpio_in_i[i]` & `prev[i]`.
  - The `armed` flag is cleared by reset and set on the first clock after reset. Edges are suppressed while `armed`=0, so the first sample after reset cannot raise a spurious edge.
- Status update: `IRQ_STATUS[i]` <= (`IRQ_STATUS[i]` & ~`w1c[i]`) | `rise[i]` | `fall[i]`. A new edge wins over a simultaneous clear of the same bit.
- `pending` = |(`IRQ_STATUS` & `IRQ_MASK`).
- Interrupt FSM:
  - IDLE: `interrupt_o`=0. Go to REQ when `pending`=1.
  - REQ: `interrupt_o`=1, held until `interrupt_ack_i`=1, then go to SERVICE. If `pending` drops to 0 before the ack (firmware cleared or masked the bit), return to IDLE.
  - SERVICE: `interrupt_o`=0. Go to IDLE when `pending`=0. This means the ISR must clear or mask every pending source before another request is raised.
  - `interrupt_ack_i` is ignored in IDLE and SERVICE.

## Timing
- Reset: all registers 8'h00, `in_port_o`=8'h00, `interrupt_o`=0, `prev`=0, `armed`=0, FSM in IDLE. Reset takes effect immediately and asynchronously, including mid-transaction and mid-interrupt.
- Write latency: a register and its `gpio_*_o` output update on the clock edge that samples `write_strobe_i`, so they are visible the following cycle.
- Read latency: 1 cycle from `port_id_i` to `in_port_o`. This fits the KCPSM 2-cycle INPUT.
- Edge latency: status sets on the edge that samples the changed `gpio_in_i`.
- Interrupt latency: `interrupt_o` rises 1 cycle after status&mask becomes non-zero and falls on the edge that samples `interrupt_ack_i`.
- A write to IRQ_MASK or IRQ_STATUS affects `pending` one cycle after the write.

## Test plan
- Reset, then read offsets 0–7 at `BASE_ADDR`=8'h40 -> all 8'h00 and `interrupt_o`=0. Read port 8'h48 -> 8'h00.
- Write 8'hA5 to offset 0, 8'h0F to offset 1, 8'hFF to offset 2 -> `gpio_data_o`=8'hA5, `gpio_oe_o`=8'h0F, `gpio_enable_o`=8'hFF the next cycle, and readback matches. Write to offset 3 -> no change. Drive `gpio_in_i`=8'h3C and read offset 3 -> 8'h3C.
- Set RISE_EN=8'h10 and IRQ_MASK=8'h10, then raise `gpio_in_i[4]` -> STATUS=8'h10 the next cycle and `interrupt_o`=1 one cycle later. Pulse `interrupt_ack_i` -> `interrupt_o`=0 and stays 0. Write 8'h10 to offset 7 -> STATUS=8'h00 and the FSM returns to IDLE.
- Set FALL_EN=8'h80 with IRQ_MASK=8'h00 and drop bit 7 -> STATUS=8'h80 and `interrupt_o` stays 0. Then write IRQ_MASK=8'h80 -> `interrupt_o`=1.
- In the same cycle, write 8'h10 to offset 7 while a new rise occurs on bit 4 -> STATUS[4] remains 1. Separately, with bit 4 configured as an output (OE[4]=1), toggling `gpio_in_i[4]` sets no status.
- Assert `rst_n_i` low while `interrupt_o`=1 -> `interrupt_o`=0 and all registers 0 immediately. After release, with `gpio_in_i`=8'hFF and all RISE_EN set, no status bit sets.

Source files
------------

// File: rtl/pb_gpio_ctrl.sv
// pb_gpio_ctrl: KCPSM port-mapped control registers for pb_gpio, plus per-pin
// edge detection feeding a sticky, maskable, acknowledged interrupt request.
module pb_gpio_ctrl #(
   parameter logic [7:0] BASE_ADDR = 8'h00
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [7:0] port_id_i,
   input  logic       write_strobe_i,
   input  logic [7:0] out_port_i,
   output logic [7:0] in_port_o,
   output logic       interrupt_o,
   input  logic       interrupt_ack_i,
   output logic [7:0] gpio_data_o,
   output logic [7:0] gpio_oe_o,
   output logic [7:0] gpio_enable_o,
   input  logic [7:0] gpio_in_i
);

   typedef enum logic [1:0] {
      IRQ_IDLE,
      IRQ_REQ,
      IRQ_SERVICE
   } irq_state_e;

   localparam logic [2:0] OFF_DATA_OUT   = 3'd0;
   localparam logic [2:0] OFF_OE         = 3'd1;
   localparam logic [2:0] OFF_ENABLE     = 3'd2;
   localparam logic [2:0] OFF_DATA_IN    = 3'd3;
   localparam logic [2:0] OFF_IRQ_MASK   = 3'd4;
   localparam logic [2:0] OFF_RISE_EN    = 3'd5;
   localparam logic [2:0] OFF_FALL_EN    = 3'd6;
   localparam logic [2:0] OFF_IRQ_STATUS = 3'd7;

   logic [7:0] data_out_q;
   logic [7:0] oe_q;
   logic [7:0] enable_q;
   logic [7:0] irq_mask_q;
   logic [7:0] rise_en_q;
   logic [7:0] fall_en_q;
   logic [7:0] irq_status_q;
   logic [7:0] prev_q;
   logic       armed_q;
   irq_state_e irq_state_q;

   logic       hit;
   logic       wr;
   logic [2:0] off;
   logic [7:0] w1c;
   logic [7:0] qual;
   logic [7:0] rise;
   logic [7:0] fall;
   logic [7:0] rd_mux;
   logic       pending;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
      rd_mux  = 8'h00;
      hit     = (port_id_i[7:3] == BASE_ADDR[7:3]);
      off     = port_id_i[2:0];
      wr      = hit & write_strobe_i;
      w1c     = (wr && (off == OFF_IRQ_STATUS)) ? out_port_i : 8'h00;
      // Only enabled pins that are not being driven by us can raise edges.
      qual    = enable_q & ~oe_q;
      rise    = armed_q ? (qual & rise_en_q & gpio_in_i & ~prev_q) : 8'h00;
      fall    = armed_q ? (qual & fall_en_q & ~gpio_in_i & prev_q) : 8'h00;
      pending = |(irq_status_q & irq_mask_q);
      case (off)
         OFF_DATA_OUT:   rd_mux = data_out_q;
         OFF_OE:         rd_mux = oe_q;
         OFF_ENABLE:     rd_mux = enable_q;
         OFF_DATA_IN:    rd_mux = gpio_in_i;
         OFF_IRQ_MASK:   rd_mux = irq_mask_q;
         OFF_RISE_EN:    rd_mux = rise_en_q;
         OFF_FALL_EN:    rd_mux = fall_en_q;
         OFF_IRQ_STATUS: rd_mux = irq_status_q;
         default:        rd_mux = 8'h00;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         data_out_q   <= 8'h00;
         oe_q         <= 8'h00;
         enable_q     <= 8'h00;
         irq_mask_q   <= 8'h00;
         rise_en_q    <= 8'h00;
         fall_en_q    <= 8'h00;
         irq_status_q <= 8'h00;
         prev_q       <= 8'h00;
         armed_q      <= 1'b0;
         in_port_o    <= 8'h00;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
         if (wr) begin
            case (off)
               OFF_DATA_OUT: data_out_q <= out_port_i;
               OFF_OE:       oe_q       <= out_port_i;
               OFF_ENABLE:   enable_q   <= out_port_i;
               OFF_IRQ_MASK: irq_mask_q <= out_port_i;
               OFF_RISE_EN:  rise_en_q  <= out_port_i;
               OFF_FALL_EN:  fall_en_q  <= out_port_i;
               default:      ;
            endcase
         end
         // A fresh edge wins over a simultaneous write-1-to-clear of the same bit.
         irq_status_q <= (irq_status_q & ~w1c) | rise | fall;
         prev_q       <= gpio_in_i;
         armed_q      <= 1'b1;
         in_port_o    <= hit ? rd_mux : 8'h00;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         irq_state_q <= IRQ_IDLE;
         interrupt_o <= 1'b0;
      end else begin
         case (irq_state_q)
            IRQ_IDLE: begin
               if (pending) begin
                  irq_state_q <= IRQ_REQ;
                  interrupt_o <= 1'b1;
               end
            end
            IRQ_REQ: begin
               if (interrupt_ack_i) begin
                  irq_state_q <= IRQ_SERVICE;
                  interrupt_o <= 1'b0;
               end else if (!pending) begin
                  irq_state_q <= IRQ_IDLE;
                  interrupt_o <= 1'b0;
               end
            end
            IRQ_SERVICE: begin
               // The ISR must retire every pending source before a new request.
               if (!pending) begin
                  irq_state_q <= IRQ_IDLE;
               end
               interrupt_o <= 1'b0;
            end
            default: begin
               irq_state_q <= IRQ_IDLE;
               interrupt_o <= 1'b0;
            end
         endcase
      end
   end

   assign gpio_data_o   = data_out_q;
   assign gpio_oe_o     = oe_q;
   assign gpio_enable_o = enable_q;

endmodule

// File: tb/tb_pb_gpio_ctrl.sv
// Scoreboard bench for pb_gpio_ctrl: stimulus steps a behavioural model and
// queues expected outputs; a negedge monitor pops and compares them.
module tb_pb_gpio_ctrl;

   localparam logic [7:0] BASE = 8'h40;

   logic       clk_i = 1'b0;
   logic       rst_n_i = 1'b0;
   logic [7:0] port_id_i = 8'h00;
   logic       write_strobe_i = 1'b0;
   logic [7:0] out_port_i = 8'h00;
   logic [7:0] in_port_o;
   logic       interrupt_o;
   logic       interrupt_ack_i = 1'b0;
   logic [7:0] gpio_data_o;
   logic [7:0] gpio_oe_o;
   logic [7:0] gpio_enable_o;
   logic [7:0] gpio_in_i = 8'h00;

   pb_gpio_ctrl #(.BASE_ADDR(BASE)) dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .port_id_i      (port_id_i),
      .write_strobe_i (write_strobe_i),
      .out_port_i     (out_port_i),
      .in_port_o      (in_port_o),
      .interrupt_o    (interrupt_o),
      .interrupt_ack_i(interrupt_ack_i),
      .gpio_data_o    (gpio_data_o),
      .gpio_oe_o      (gpio_oe_o),
      .gpio_enable_o  (gpio_enable_o),
      .gpio_in_i      (gpio_in_i)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef enum int {S_INPORT, S_IRQ, S_DATA, S_OE, S_EN} sel_e;
   typedef struct {
      string      name;
      int         due;
      sel_e       sel;
      logic [7:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: register file by offset, last pin sample, and the
   // request/in-service flags of the interrupt handshake.
   logic [7:0] m_reg [8];
   logic [7:0] m_prev;
   logic       m_armed;
   logic       m_req;
   logic       m_svc;
   logic [7:0] cur_gin = 8'h00;

   function automatic void push(string name, int due, sel_e sel, logic [7:0] val);
      exp_t e;
      e.name = name;
      e.due  = due;
      e.sel  = sel;
      e.val  = val;
      sb.push_back(e);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
      m_prev  = 8'h00;
      m_armed = 1'b0;
      m_req   = 1'b0;
      m_svc   = 1'b0;
   endfunction

   // Drive one cycle of inputs now; the model computes what the next edge produces.
   task automatic drive_model(input logic [7:0] port, input logic ws, input logic [7:0] data,
                              input logic ack, input logic [7:0] gin, input string tag);
      logic       hit;
      int         off;
      logic [7:0] exp_in, w1c, qual, rise, fall;
      logic       pending;
      port_id_i       = port;
      write_strobe_i  = ws;
      out_port_i      = data;
      interrupt_ack_i = ack;
      gpio_in_i       = gin;

      hit     = (port[7:3] == BASE[7:3]);
      off     = int'(port[2:0]);
      exp_in  = !hit ? 8'h00 : (off == 3) ? gin : m_reg[off];
      pending = (m_reg[7] & m_reg[4]) != 8'h00;
      qual    = m_reg[2] & ~m_reg[1];
      rise    = 8'h00;
      fall    = 8'h00;
      if (m_armed) begin
         for (int b = 0; b < 8; b++) begin
            if (qual[b] && m_reg[5][b] && gin[b] && !m_prev[b]) rise[b] = 1'b1;
            if (qual[b] && m_reg[6][b] && !gin[b] && m_prev[b]) fall[b] = 1'b1;
         end
      end
      w1c = (hit && ws && off == 7) ? data : 8'h00;

      if (m_req) begin
         if (ack) begin
            m_req = 1'b0;
            m_svc = 1'b1;
         end else if (!pending) begin
            m_req = 1'b0;
         end
      end else if (m_svc) begin
         if (!pending) m_svc = 1'b0;
      end else if (pending) begin
         m_req = 1'b1;
      end

      m_reg[7] = (m_reg[7] & ~w1c) | rise | fall;
      if (hit && ws && off != 3 && off != 7) m_reg[off] = data;
      m_prev  = gin;
      m_armed = 1'b1;

      push(tag,        cyc + 1, S_INPORT, exp_in);
      push("irq",      cyc + 1, S_IRQ,    {7'h00, m_req});
      push("gpio_dat", cyc + 1, S_DATA,   m_reg[0]);
      push("gpio_oe",  cyc + 1, S_OE,     m_reg[1]);
      push("gpio_en",  cyc + 1, S_EN,     m_reg[2]);
   endtask

   task automatic step(input logic [7:0] port, input logic ws, input logic [7:0] data,
                       input logic ack, input logic [7:0] gin, input string tag);
      @(posedge clk_i);
      #1;
      drive_model(port, ws, data, ack, gin, tag);
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data);
      step(addr, 1'b1, data, 1'b0, cur_gin, "wr_cycle");
   endtask

   task automatic rd(input logic [7:0] addr, input string tag);
      step(addr, 1'b0, 8'h00, 1'b0, cur_gin, tag);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(8'h00, 1'b0, 8'h00, 1'b0, cur_gin, "idle");
   endtask

   // Assert reset mid-cycle, check outputs cleared before the next edge, release.
   task automatic apply_reset(input logic [7:0] gin);
      @(posedge clk_i);
      #2;
      rst_n_i         = 1'b0;
      port_id_i       = 8'h00;
      write_strobe_i  = 1'b0;
      out_port_i      = 8'h00;
      interrupt_ack_i = 1'b0;
      gpio_in_i       = gin;
      cur_gin         = gin;
      sb.delete();
      model_reset();
      push("rst_in_port", cyc, S_INPORT, 8'h00);
      push("rst_irq",     cyc, S_IRQ,    8'h00);
      push("rst_data",    cyc, S_DATA,   8'h00);
      push("rst_oe",      cyc, S_OE,     8'h00);
      push("rst_en",      cyc, S_EN,     8'h00);
      repeat (2) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      drive_model(8'h00, 1'b0, 8'h00, 1'b0, gin, "post_release");
   endtask

   always @(negedge clk_i) begin
      logic [7:0] act;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due <= cyc) begin
            case (sb[i].sel)
               S_INPORT: act = in_port_o;
               S_IRQ:    act = {7'h00, interrupt_o};
               S_DATA:   act = gpio_data_o;
               S_OE:     act = gpio_oe_o;
               default:  act = gpio_enable_o;
            endcase
            n_tests++;
            if (sb[i].due < cyc) begin
               n_fail++;
               $display("FAIL %s stale entry due %0d at cyc %0d", sb[i].name, sb[i].due, cyc);
            end else if (act !== sb[i].val) begin
               n_fail++;
               $display("FAIL %s at cyc %0d: actual %02h, required %02h",
                        sb[i].name, cyc, act, sb[i].val);
            end
            sb.delete(i);
         end
      end
   end

   initial begin
      model_reset();
      apply_reset(8'h00);

      for (int i = 0; i < 8; i++) rd(BASE + 8'(i), "rst_readback");
      rd(8'h48, "miss_48");

      wr(BASE + 8'd0, 8'hA5);
      wr(BASE + 8'd1, 8'h0F);
      wr(BASE + 8'd2, 8'hFF);
      rd(BASE + 8'd0, "rd_data_out");
      rd(BASE + 8'd1, "rd_oe");
      rd(BASE + 8'd2, "rd_enable");
      wr(BASE + 8'd3, 8'h77);
      rd(BASE + 8'd3, "rd_data_in_ro");
      cur_gin = 8'h3C;
      rd(BASE + 8'd3, "rd_data_in");

      wr(BASE + 8'd5, 8'h10);
      wr(BASE + 8'd4, 8'h10);
      cur_gin = 8'h2C;
      idle(2);
      cur_gin = 8'h3C;
      idle(3);
      rd(BASE + 8'd7, "status_rise");
      step(8'h00, 1'b0, 8'h00, 1'b1, cur_gin, "ack");
      idle(3);
      wr(BASE + 8'd7, 8'h10);
      idle(2);
      rd(BASE + 8'd7, "status_cleared");

      wr(BASE + 8'd6, 8'h80);
      wr(BASE + 8'd4, 8'h00);
      cur_gin = 8'hBC;
      idle(2);
      cur_gin = 8'h3C;
      idle(2);
      rd(BASE + 8'd7, "status_fall");
      wr(BASE + 8'd4, 8'h80);
      idle(3);
      wr(BASE + 8'd7, 8'h80);
      idle(2);

      cur_gin = 8'h2C;
      idle(1);
      cur_gin = 8'h3C;
      idle(1);
      cur_gin = 8'h2C;
      idle(1);
      cur_gin = 8'h3C;
      step(BASE + 8'd7, 1'b1, 8'h10, 1'b0, cur_gin, "w1c_race");
      idle(1);
      rd(BASE + 8'd7, "race_status");

      wr(BASE + 8'd7, 8'hFF);
      wr(BASE + 8'd1, 8'h1F);
      for (int i = 0; i < 4; i++) begin
         cur_gin = cur_gin ^ 8'h10;
         idle(1);
      end
      rd(BASE + 8'd7, "oe_status");

      wr(BASE + 8'd1, 8'h0F);
      wr(BASE + 8'd4, 8'h10);
      cur_gin = 8'h2C;
      idle(1);
      cur_gin = 8'h3C;
      idle(3);
      apply_reset(8'hFF);
      for (int i = 0; i < 8; i++) rd(BASE + 8'(i), "post_rst_readback");
      wr(BASE + 8'd5, 8'hFF);
      wr(BASE + 8'd2, 8'hFF);
      idle(3);
      rd(BASE + 8'd7, "post_rst_status");

      for (int i = 0; i < 600; i++) begin
         logic [7:0] port, data, gin;
         logic       ws, ack;
         port = 8'($urandom_range(8'h38, 8'h4F));
         ws   = 1'($urandom_range(0, 1));
         data = 8'($urandom);
         ack  = ($urandom_range(0, 5) == 0);
         gin  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : cur_gin;
         cur_gin = gin;
         step(port, ws, data, ack, gin, "rand_in_port");
      end

      repeat (3) @(posedge clk_i);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: actual %0d entries left, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
